path_delay_meter: RTL and testbench

Launch-and-capture timing probe for characterising gate chains built from the team's standard cells (BUF, NOT, NAND, NOR, DFF). The meter drives a transition into a path under test. It then waits for that transition to return and reports the round-trip delay in clock cycles, or flags a timeout. It is the launching end paired with the capturing flip-flop end of a timed path, and sits in the timing-analysis test harnesses.

---
 rtl/path_delay_meter.sv | 123 ++++++++++++
 tb/tb_path_delay_meter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/path_delay_meter.sv
// path_delay_meter: launch-and-capture timing probe for a path under test.
// Toggles LAUNCH, waits for the transition to come back on RET (through a
// synchroniser), and reports the round-trip delay in clock cycles, or a timeout.
//
// Parameters:
//   CNT_W        width of the cycle counter and DELAY
//   TIMEOUT      last counter value at which the meter still waits (1..2^CNT_W-2)
//   SYNC_STAGES  length of the RET synchroniser chain (>= 2)
// Ports:
//   C             clock, rising edge
//   R             asynchronous active-low reset
//   START         measurement request
//   RET           returning end of the path under test (asynchronous to C)
//   LAUNCH        drives the input of the path under test
//   BUSY          high whenever a measurement is in progress or reporting
//   DONE          one-cycle pulse when a result is valid
//   TIMEOUT_FLAG  last measurement timed out
//   DELAY         last measured delay in cycles, all-ones on timeout
module path_delay_meter #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             C,
  input  logic             R,
  input  logic             START,
  input  logic             RET,
  output logic             LAUNCH,
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT_FLAG,
  output logic [CNT_W-1:0] DELAY
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWait, StReport} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   launch_q, launch_d;
  logic                   prior_q, prior_d;
  logic                   done_q, done_d;
  logic                   tflag_q, tflag_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       delay_q, delay_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      sync_q   <= '0;
      state_q  <= StIdle;
      launch_q <= 1'b0;
      prior_q  <= 1'b0;
      done_q   <= 1'b0;
      tflag_q  <= 1'b0;
      cnt_q    <= '0;
      delay_q  <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], RET};
      state_q  <= state_d;
      launch_q <= launch_d;
      prior_q  <= prior_d;
      done_q   <= done_d;
      tflag_q  <= tflag_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    launch_d = launch_q;
    prior_d  = prior_q;
    done_d   = 1'b0;
    tflag_d  = tflag_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    unique case (state_q)
      StIdle: begin
        // Only launch once the path has settled to the current LAUNCH level.
        if (START && (sync == launch_q)) begin
          launch_d = ~launch_q;
          prior_d  = launch_q;
          cnt_d    = '0;
          tflag_d  = 1'b0;
          state_d  = StWait;
        end
      end
      StWait: begin
        // A match wins over a timeout on the same edge.
        if (sync == launch_q) begin
          delay_d = cnt_q;
          done_d  = 1'b1;
          state_d = StReport;
        end else if (cnt_q == TimeoutVal) begin
          delay_d  = '1;
          tflag_d  = 1'b1;
          done_d   = 1'b1;
          launch_d = prior_q;
          state_d  = StReport;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StReport: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign LAUNCH       = launch_q;
  assign BUSY         = (state_q != StIdle);
  assign DONE         = done_q;
  assign TIMEOUT_FLAG = tflag_q;
  assign DELAY        = delay_q;

endmodule

// File: tb/tb_path_delay_meter.sv
module tb_path_delay_meter;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       START = 1'b0;
  logic       RET;
  logic       LAUNCH, BUSY, DONE, TIMEOUT_FLAG;
  logic [7:0] DELAY;

  // 0: loopback, 1: 10-DFF chain, 2: forced level
  int         mode = 0;
  logic       force_val = 1'b0;
  logic [9:0] chain;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       tf;
    logic [7:0] dly;
  } exp_t;
  exp_t sb[$];

  path_delay_meter #(
    .CNT_W      (8),
    .TIMEOUT    (200),
    .SYNC_STAGES(2)
  ) dut (
    .C           (C),
    .R           (R),
    .START       (START),
    .RET         (RET),
    .LAUNCH      (LAUNCH),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .TIMEOUT_FLAG(TIMEOUT_FLAG),
    .DELAY       (DELAY)
  );

  always #5 C = ~C;

  always_ff @(posedge C or negedge R) begin
    if (!R) chain <= '0;
    else    chain <= {chain[8:0], LAUNCH};
  end

  always_comb begin
    case (mode)
      0:       RET = LAUNCH;
      1:       RET = chain[9];
      default: RET = force_val;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every DONE pulse must match the oldest expected result.
  always @(negedge C) begin
    if (R && DONE) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_done observed=1 expected=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("delay", 32'(DELAY), 32'(e.dly));
        chk("timeout_flag", 32'(TIMEOUT_FLAG), 32'(e.tf));
      end
    end
  end

  // One START pulse; checks launch, DONE edge index and return to idle.
  task automatic measure(input string tag, input logic [7:0] exp_dly, input logic exp_tf,
                         input int exp_edges, input logic exp_launch,
                         input logic exp_launch_done);
    int n;
    sb.push_back('{tf: exp_tf, dly: exp_dly});
    @(negedge C);
    START = 1'b1;
    @(negedge C);  // E0 happened in between
    START = 1'b0;
    chk({tag, "_busy_e0"}, 32'(BUSY), 32'd1);
    chk({tag, "_launch_e0"}, 32'(LAUNCH), 32'(exp_launch));
    chk({tag, "_tflag_clr"}, 32'(TIMEOUT_FLAG), 32'd0);
    n = 0;
    while (n < 400) begin
      @(negedge C);
      n++;
      if (DONE) break;
    end
    chk({tag, "_done_edge"}, 32'(n), 32'(exp_edges));
    chk({tag, "_launch_done"}, 32'(LAUNCH), 32'(exp_launch_done));
    @(negedge C);
    chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge C);
    chk("rst_launch", 32'(LAUNCH), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_tflag", 32'(TIMEOUT_FLAG), 32'd0);
    chk("rst_delay", 32'(DELAY), 32'd0);
    R = 1'b1;
    repeat (2) @(negedge C);

    // Zero-delay loopback, both polarities
    mode = 0;
    measure("loop_rise", 8'd2, 1'b0, 3, 1'b1, 1'b1);
    measure("loop_fall", 8'd2, 1'b0, 3, 1'b0, 1'b0);

    // 10-DFF delayed path, both polarities
    mode = 1;
    repeat (12) @(negedge C);
    measure("chain_rise", 8'd12, 1'b0, 13, 1'b1, 1'b1);
    repeat (12) @(negedge C);
    measure("chain_fall", 8'd12, 1'b0, 13, 1'b0, 1'b0);

    // RET stuck at 0: timeout at E201 restores LAUNCH
    mode = 2;
    force_val = 1'b0;
    repeat (3) @(negedge C);
    measure("tmo", 8'hff, 1'b1, 201, 1'b1, 1'b0);
    repeat (3) @(negedge C);
    chk("tmo_flag_hold", 32'(TIMEOUT_FLAG), 32'd1);
    chk("tmo_delay_hold", 32'(DELAY), 32'd255);
    mode = 0;
    measure("after_tmo", 8'd2, 1'b0, 3, 1'b1, 1'b1);

    // START held high through WAIT and REPORT: one measurement only
    sb.push_back('{tf: 1'b0, dly: 8'd2});
    @(negedge C);
    START = 1'b1;
    @(negedge C);
    chk("hold_launch_e0", 32'(LAUNCH), 32'd0);
    repeat (3) @(negedge C);
    chk("hold_done", 32'(DONE), 32'd1);
    @(negedge C);  // after E4: START was sampled in REPORT
    START = 1'b0;
    chk("hold_busy_e4", 32'(BUSY), 32'd0);
    @(negedge C);
    chk("hold_busy_e5", 32'(BUSY), 32'd0);
    chk("hold_launch_end", 32'(LAUNCH), 32'd0);

    // RET forced to 1 while LAUNCH=0: path unsettled, START ignored
    mode = 2;
    force_val = 1'b1;
    repeat (3) @(negedge C);
    START = 1'b1;
    repeat (2) @(negedge C);
    START = 1'b0;
    chk("unsettled_busy", 32'(BUSY), 32'd0);
    chk("unsettled_launch", 32'(LAUNCH), 32'd0);
    mode = 0;
    repeat (3) @(negedge C);

    // Reset mid-WAIT on a delayed run
    mode = 1;
    @(negedge C);
    START = 1'b1;
    @(posedge C);  // E0
    #1 START = 1'b0;
    repeat (5) @(posedge C);  // E5
    #2 R = 1'b0;
    #1;
    chk("midrst_launch", 32'(LAUNCH), 32'd0);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_delay", 32'(DELAY), 32'd0);
    @(negedge C);
    R = 1'b1;
    mode = 0;
    repeat (2) @(negedge C);
    measure("after_rst", 8'd2, 1'b0, 3, 1'b1, 1'b1);

    repeat (2) @(negedge C);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
